// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the AXI-Stream deadlock monitor.
package aesl_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2
  } dl_state_e;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2_f(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/aesl_deadlock_grp_reduce.sv
// Per-group reduction: group blocked flag and idle-masked stream map slice.
module aesl_deadlock_grp_reduce #(
  parameter int GROUP_SIZE = 2
) (
  input  logic [GROUP_SIZE-1:0] axis_sigs,
  input  logic                  idle,
  output logic                  grp_blk,
  output logic [GROUP_SIZE-1:0] info_slice
);

  assign grp_blk    = (|axis_sigs) & ~idle;
  assign info_slice = grp_blk ? axis_sigs : '0;

endmodule

// File: rtl/aesl_deadlock_axis_monitor.sv
// Parametrised AXI-Stream deadlock monitor with persistence filter,
// sticky flag, first-block snapshot and saturating blocked-cycle counter.
module aesl_deadlock_axis_monitor
  import aesl_deadlock_pkg::*;
#(
  parameter int NUM_GROUPS     = 2,
  parameter int GROUP_SIZE     = 2,
  parameter int PERSIST_CYCLES = 16,
  parameter int CNT_W          = 16,
  localparam int NUM_AXIS      = NUM_GROUPS * GROUP_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [NUM_AXIS-1:0]   axis_block_sigs,
  input  logic [NUM_GROUPS-1:0] inst_idle_sigs,
  input  logic [NUM_GROUPS-1:0] inst_block_sigs,
  output logic [NUM_AXIS-1:0]   axis_block_info,
  output logic                  block,
  output logic                  block_sticky,
  output logic [NUM_AXIS-1:0]   first_info,
  output logic [CNT_W-1:0]      block_count
);

  localparam int PW = clog2_f(PERSIST_CYCLES + 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PERSIST_CYCLES - 1);

  logic [NUM_GROUPS-1:0] grp_blk;
  logic [NUM_AXIS-1:0]   info_d;
  logic [NUM_AXIS-1:0]   info_q;
  logic                  raw;
  dl_state_e             state, state_n;
  logic [PW-1:0]         pcnt, pcnt_n;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    aesl_deadlock_grp_reduce #(
      .GROUP_SIZE(GROUP_SIZE)
    ) u_grp (
      .axis_sigs (axis_block_sigs[g*GROUP_SIZE +: GROUP_SIZE]),
      .idle      (inst_idle_sigs[g]),
      .grp_blk   (grp_blk[g]),
      .info_slice(info_d[g*GROUP_SIZE +: GROUP_SIZE])
    );
  end

  assign raw = (|grp_blk) | (|inst_block_sigs);

  // Persistence filter: a single raw-low cycle always drops back to IDLE.
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    case (state)
      IDLE: begin
        pcnt_n = '0;
        if (raw) begin
          if (PERSIST_CYCLES == 1) begin
            state_n = BLOCKED;
          end else begin
            state_n = SUSPECT;
            pcnt_n  = PW'(1);
          end
        end
      end
      SUSPECT: begin
        if (!raw) begin
          state_n = IDLE;
          pcnt_n  = '0;
        end else if (pcnt == PCNT_LAST) begin
          state_n = BLOCKED;
        end else begin
          pcnt_n = pcnt + PW'(1);
        end
      end
      BLOCKED: begin
        if (!raw) begin
          state_n = IDLE;
          pcnt_n  = '0;
        end
      end
      default: begin
        state_n = IDLE;
        pcnt_n  = '0;
      end
    endcase
  end

  assign block           = (state == BLOCKED);
  assign axis_block_info = block ? info_q : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      pcnt         <= '0;
      info_q       <= '0;
      block_sticky <= 1'b0;
      first_info   <= '0;
      block_count  <= '0;
    end else begin
      state  <= state_n;
      pcnt   <= pcnt_n;
      info_q <= info_d;

      if (clear) begin
        block_sticky <= 1'b0;
      end else if (state_n == BLOCKED) begin
        block_sticky <= 1'b1;
      end

      // Snapshot only the first entry into BLOCKED since reset or clear.
      if (!clear && !block_sticky && (state != BLOCKED) && (state_n == BLOCKED)) begin
        first_info <= info_d;
      end

      if (clear) begin
        block_count <= '0;
      end else if (block && (block_count != {CNT_W{1'b1}})) begin
        block_count <= block_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aesl_deadlock_axis_monitor.sv
// Self-checking bench: three monitor configurations share the stimulus and
// are compared every cycle against a run-length based reference model.
module tb_aesl_deadlock_axis_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic [3:0] axis;
  logic [1:0] idle;
  logic [1:0] iblk;

  logic       o_blk   [3];
  logic       o_st    [3];
  logic [3:0] o_first [3];
  logic [3:0] o_info  [3];
  logic [15:0] o_cnt  [3];
  logic [3:0] cnt_c;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         run   [3];
  logic       mblk  [3];
  logic       mst   [3];
  logic [3:0] mfirst[3];
  int         mcnt  [3];
  logic [3:0] minfo;
  int PERS [3] = '{16, 1, 3};
  int CMAX [3] = '{65535, 65535, 15};

  always #5 clock = ~clock;

  aesl_deadlock_axis_monitor dut_a (
    .clock(clock), .reset(reset), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
    .axis_block_info(o_info[0]), .block(o_blk[0]), .block_sticky(o_st[0]),
    .first_info(o_first[0]), .block_count(o_cnt[0])
  );

  aesl_deadlock_axis_monitor #(.PERSIST_CYCLES(1)) dut_b (
    .clock(clock), .reset(reset), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
    .axis_block_info(o_info[1]), .block(o_blk[1]), .block_sticky(o_st[1]),
    .first_info(o_first[1]), .block_count(o_cnt[1])
  );

  aesl_deadlock_axis_monitor #(.PERSIST_CYCLES(3), .CNT_W(4)) dut_c (
    .clock(clock), .reset(reset), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
    .axis_block_info(o_info[2]), .block(o_blk[2]), .block_sticky(o_st[2]),
    .first_info(o_first[2]), .block_count(cnt_c)
  );
  assign o_cnt[2] = {12'd0, cnt_c};

  typedef struct {
    logic [3:0] axis;
    logic [1:0] idle;
    logic [1:0] iblk;
    logic       eblk;
    logic [3:0] einfo;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: advance the model from the current inputs, then compare.
  task automatic tick();
    logic       raw;
    logic [3:0] info_n;
    int         nrun;
    logic       nb;
    raw    = 1'b0;
    info_n = 4'b0;
    for (int g = 0; g < 2; g++) begin
      if ((axis[2*g +: 2] != 2'b00) && !idle[g]) begin
        raw = 1'b1;
        info_n[2*g +: 2] = axis[2*g +: 2];
      end
    end
    if (iblk != 2'b00) raw = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        run[k] = 0; mblk[k] = 0; mst[k] = 0; mfirst[k] = 0; mcnt[k] = 0;
      end else begin
        nrun = raw ? ((run[k] < 1000) ? run[k] + 1 : 1000) : 0;
        nb   = (nrun >= PERS[k]);
        if (!mblk[k] && nb && !mst[k] && !clear) mfirst[k] = info_n;
        if (clear) mcnt[k] = 0;
        else if (mblk[k] && mcnt[k] < CMAX[k]) mcnt[k] = mcnt[k] + 1;
        mst[k]  = clear ? 1'b0 : (mst[k] | nb);
        mblk[k] = nb;
        run[k]  = nrun;
      end
    end
    minfo = reset ? 4'b0 : info_n;
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_block[%0d]", k), 32'(o_blk[k]), 32'(mblk[k]));
      chk($sformatf("model_sticky[%0d]", k), 32'(o_st[k]), 32'(mst[k]));
      chk($sformatf("model_first[%0d]", k), 32'(o_first[k]), 32'(mfirst[k]));
      chk($sformatf("model_info[%0d]", k), 32'(o_info[k]), 32'(mblk[k] ? minfo : 4'b0));
      chk($sformatf("model_count[%0d]", k), 32'(o_cnt[k]), 32'(mcnt[k]));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; axis = 4'b0; idle = 2'b0; iblk = 2'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4'b0000, 2'b00, 2'b00, 1'b0, 4'b0000};
    tbl[1] = '{4'b0010, 2'b00, 2'b00, 1'b1, 4'b0010};
    tbl[2] = '{4'b1000, 2'b00, 2'b00, 1'b1, 4'b1000};
    tbl[3] = '{4'b1100, 2'b10, 2'b00, 1'b0, 4'b0000};
    tbl[4] = '{4'b1100, 2'b10, 2'b01, 1'b1, 4'b0000};
    tbl[5] = '{4'b0011, 2'b01, 2'b00, 1'b0, 4'b0000};
    tbl[6] = '{4'b0101, 2'b00, 2'b00, 1'b1, 4'b0101};
    tbl[7] = '{4'b0101, 2'b11, 2'b10, 1'b1, 4'b0000};
    tbl[8] = '{4'b0000, 2'b00, 2'b00, 1'b0, 4'b0000};

    do_reset();
    chk("reset_block", 32'(o_blk[0]), 0);
    chk("reset_sticky", 32'(o_st[0]), 0);
    chk("reset_first", 32'(o_first[0]), 0);
    chk("reset_count", 32'(o_cnt[0]), 0);
    chk("reset_info", 32'(o_info[0]), 0);

    // Table vectors on the one-cycle-latency instance
    for (int i = 0; i < 9; i++) begin
      axis = tbl[i].axis; idle = tbl[i].idle; iblk = tbl[i].iblk;
      tick();
      chk($sformatf("tbl_block[%0d]", i), 32'(o_blk[1]), 32'(tbl[i].eblk));
      chk($sformatf("tbl_info[%0d]", i), 32'(o_info[1]), 32'(tbl[i].einfo));
    end

    // Steady stall on stream 1
    do_reset();
    axis = 4'b0010;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) chk("persist_block_t15", 32'(o_blk[0]), 0);
      if (i == 16) begin
        chk("persist_block_t16", 32'(o_blk[0]), 1);
        chk("persist_info_t16", 32'(o_info[0]), 4'b0010);
      end
      if (i == 20) chk("persist_count_t20", 32'(o_cnt[0]), 4);
    end

    // One-cycle gap restarts the count
    do_reset();
    for (int i = 1; i <= 28; i++) begin
      axis = (i == 11) ? 4'b0000 : 4'b0010;
      tick();
      if (i == 26) begin
        chk("gap_block_t26", 32'(o_blk[0]), 0);
        chk("gap_sticky_t26", 32'(o_st[0]), 0);
      end
      if (i == 27) chk("gap_block_t27", 32'(o_blk[0]), 1);
    end

    // Single-cycle pulse with PERSIST_CYCLES = 1
    do_reset();
    axis = 4'b1000;
    tick();
    chk("pulse_block_t1", 32'(o_blk[1]), 1);
    axis = 4'b0000;
    tick();
    chk("pulse_block_t2", 32'(o_blk[1]), 0);
    chk("pulse_first", 32'(o_first[1]), 4'b1000);
    chk("pulse_sticky", 32'(o_st[1]), 1);

    // Idle group masks its streams; child block still triggers
    do_reset();
    axis = 4'b1100; idle = 2'b10;
    for (int i = 0; i < 20; i++) tick();
    chk("idle_mask_block", 32'(o_blk[0]), 0);
    iblk = 2'b01;
    for (int i = 1; i <= 16; i++) tick();
    chk("child_block", 32'(o_blk[0]), 1);
    chk("child_info", 32'(o_info[0]), 4'b0000);

    // Saturation, clear while blocked, snapshot reload (CNT_W = 4)
    do_reset();
    axis = 4'b0001;
    for (int i = 0; i < 40; i++) tick();
    chk("sat_count", 32'(o_cnt[2]), 15);
    clear = 1'b1;
    tick();
    chk("clr_count", 32'(o_cnt[2]), 0);
    chk("clr_sticky", 32'(o_st[2]), 0);
    clear = 1'b0;
    tick();
    chk("clr_count_next", 32'(o_cnt[2]), 1);
    chk("clr_sticky_next", 32'(o_st[2]), 1);
    axis = 4'b0000; tick();
    axis = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    chk("first_held", 32'(o_first[2]), 4'b0001);
    axis = 4'b0000; tick();
    clear = 1'b1; tick(); clear = 1'b0;
    axis = 4'b0100;
    for (int i = 0; i < 3; i++) tick();
    chk("first_reload", 32'(o_first[2]), 4'b0100);

    // Reset while BLOCKED with raw still high
    do_reset();
    axis = 4'b0010;
    for (int i = 0; i < 18; i++) tick();
    chk("pre_reset_block", 32'(o_blk[0]), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_block", 32'(o_blk[0]), 0);
    chk("rst_sticky", 32'(o_st[0]), 0);
    chk("rst_count", 32'(o_cnt[0]), 0);
    chk("rst_first", 32'(o_first[0]), 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("rst_restart_t15", 32'(o_blk[0]), 0);
      if (i == 16) chk("rst_restart_t16", 32'(o_blk[0]), 1);
    end

    // Randomised segments of held inputs
    do_reset();
    for (int s = 0; s < 150; s++) begin
      int len;
      len  = $urandom_range(30, 1);
      axis = ($urandom_range(3, 0) == 0) ? 4'b0000 : 4'($urandom);
      idle = ($urandom_range(2, 0) == 0) ? 2'($urandom) : 2'b00;
      iblk = ($urandom_range(5, 0) == 0) ? 2'($urandom) : 2'b00;
      for (int c = 0; c < len; c++) begin
        clear = ($urandom_range(19, 0) == 0);
        reset = ($urandom_range(199, 0) == 0);
        tick();
      end
    end
    reset = 1'b0; clear = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
